dispatch_multi: RTL

//  Multi-unit dispatch controller between the host dispatch interface and NU personality units.

---
 rtl/dispatch_multi.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/dispatch_multi.sv
// Multi-unit dispatch controller: AEG register file, CAEP0/CAEP1 decode, unit reset/start sequencing.
// Optional watchdog on the BUSY phase is enabled by defining DISPATCH_WDOG_EN.
module dispatch_multi #(
  parameter int unsigned FREQ   = 0,
  parameter int unsigned PART   = 0,
  parameter int unsigned NA     = 8,
  parameter int unsigned NU     = 4,
  parameter int unsigned HOLD   = 3,
  parameter int unsigned WDOG_W = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          disp_inst_vld,
  input  logic [4:0]    disp_inst,
  input  logic [17:0]   disp_aeg_idx,
  input  logic          disp_aeg_rd,
  input  logic          disp_aeg_wr,
  input  logic [63:0]   disp_aeg_wr_data,
  output logic [17:0]   disp_aeg_cnt,
  output logic [15:0]   disp_exception,
  output logic [63:0]   disp_rtn_data,
  output logic          disp_rtn_data_vld,
  output logic          disp_idle,
  output logic          disp_stall,
  input  logic [3:0]    num_ae,
  output logic [15:0]   ctlQueWidth,
  output logic [47:0]   ctlQueBase,
  output logic [NU-1:0] start,
  output logic          reset_top,
  input  logic [NU-1:0] busy
);

  localparam int unsigned IW = $clog2(NA);
  localparam logic [3:0] HoldC = 4'(HOLD);
  localparam logic [63:0] MaskRst = {{(64 - NU){1'b0}}, {NU{1'b1}}};
  localparam bit ParamsOk = (NA >= 7) && (NA <= 64) && (NU >= 1) && (NU <= 16) &&
                            (HOLD >= 1) && (HOLD <= 15) && (WDOG_W >= 1) && (WDOG_W <= 64);

  if (!ParamsOk) begin : g_bad_params
    $error("dispatch_multi: parameter out of legal range");
  end

  typedef enum logic [1:0] {StIdle, StReset, StStart, StBusy} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [NU-1:0]   mask_q, mask_d, done_q, done_d, busy_prev_q, start_q, start_d;
  logic            caep1_q, caep1_d, idle_q;
  logic [15:0]     exc_q, exc_d;
  logic [63:0]     rtn_q, rtn_d;
  logic            rtn_vld_q;
  logic [63:0]     aeg_q [NA];
  logic [63:0]     aeg_d [NA];
  logic [63:0]     status;
  logic            kick, idx_ok, wdog_exp, caep1_eff;
  logic [IW-1:0]   widx;
  logic [15:0]     que_w;

  assign kick   = disp_inst_vld && (disp_inst <= 5'd1);
  assign idx_ok = disp_aeg_idx < 18'(NA);
  assign widx   = disp_aeg_idx[IW-1:0];

`ifdef DISPATCH_WDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d   = wdog_q;
    wdog_exp = 1'b0;
    if (state_q == StStart) begin
      wdog_d = '0;
    end else if (state_q == StBusy) begin
      wdog_d   = wdog_q + 1'b1;
      wdog_exp = (aeg_q[6] != 64'd0) && (wdog_d == aeg_q[6][WDOG_W-1:0]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wdog_q <= '0;
    else          wdog_q <= wdog_d;
  end
`else
  assign wdog_exp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    done_d  = done_q;
    caep1_d = caep1_q;
    unique case (state_q)
      StIdle: begin
        if (kick) begin
          mask_d  = aeg_q[5][NU-1:0];
          done_d  = '0;
          cnt_d   = HoldC;
          caep1_d = (disp_inst == 5'd1);
          state_d = StReset;
        end
      end
      StReset: begin
        if (cnt_q == 4'd0) state_d = StStart;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StStart: begin
        cnt_d   = HoldC;
        state_d = StBusy;
      end
      StBusy: begin
        done_d = done_q | (busy_prev_q & ~busy & mask_q);
        // Watchdog expiry abandons the operation without reporting completion.
        if (wdog_exp) begin
          state_d = StIdle;
        end else if (|(busy & mask_q)) begin
          cnt_d = HoldC;
        end else if (cnt_q == 4'd0) begin
          state_d = StIdle;
          done_d  = done_d | mask_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    start_d = (state_d == StStart) ? mask_q : '0;
  end

  always_comb begin
    exc_d    = '0;
    exc_d[0] = disp_inst_vld && (disp_inst > 5'd1);
    exc_d[1] = (disp_aeg_rd || disp_aeg_wr) && !idx_ok;
    exc_d[2] = wdog_exp;
    exc_d[3] = kick && (state_q != StIdle);
  end

  always_comb begin
    for (int i = 0; i < NA; i++) begin
      aeg_d[i] = aeg_q[i];
      if (disp_aeg_wr && idx_ok && (widx == IW'(i))) begin
        if (i == 5)               aeg_d[i] = {{(64 - NU){1'b0}}, disp_aeg_wr_data[NU-1:0]};
        else if (i < 2 || i > 4)  aeg_d[i] = disp_aeg_wr_data;
      end
    end
    aeg_d[1] = aeg_d[1] | {48'd0, exc_q};
    aeg_d[2] = '0;
    aeg_d[3] = '0;
    aeg_d[4] = '0;
  end

  always_comb begin
    status           = '0;
    status[0]        = (state_d == StIdle);
    status[8 +: NU]  = done_q;
    status[24 +: NU] = busy;
    rtn_d = '0;
    if (disp_aeg_rd) begin
      if (!idx_ok) begin
        rtn_d = 64'hdeadbeefdeadbeef;
      end else begin
        case (widx)
          IW'(2):  rtn_d = 64'(PART);
          IW'(3):  rtn_d = {28'd0, num_ae, 16'(FREQ), 8'h01, 8'(NU)};
          IW'(4):  rtn_d = status;
          default: rtn_d = aeg_q[widx];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mask_q      <= '0;
      done_q      <= '0;
      busy_prev_q <= '0;
      start_q     <= '0;
      caep1_q     <= 1'b0;
      idle_q      <= 1'b1;
      exc_q       <= '0;
      rtn_q       <= '0;
      rtn_vld_q   <= 1'b0;
      for (int i = 0; i < NA; i++) aeg_q[i] <= (i == 5) ? MaskRst : 64'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      done_q      <= done_d;
      busy_prev_q <= busy;
      start_q     <= start_d;
      caep1_q     <= caep1_d;
      idle_q      <= (state_d == StIdle);
      exc_q       <= exc_d;
      rtn_q       <= rtn_d;
      rtn_vld_q   <= disp_aeg_rd;
      for (int i = 0; i < NA; i++) aeg_q[i] <= aeg_d[i];
    end
  end

  // In IDLE the flag is not latched yet, so a kick is classified from the live opcode.
  assign caep1_eff = (state_q == StIdle) ? (disp_inst == 5'd1) : caep1_q;
  assign disp_stall = !caep1_eff && (!idle_q || kick);

  assign que_w             = aeg_q[0][63:48];
  assign ctlQueWidth       = (que_w < 16'd9 || que_w > 16'd25) ? 16'd9 : que_w;
  assign ctlQueBase        = aeg_q[0][47:0];
  assign disp_aeg_cnt      = 18'(NA);
  assign disp_exception    = exc_q;
  assign disp_rtn_data     = rtn_q;
  assign disp_rtn_data_vld = rtn_vld_q;
  assign disp_idle         = idle_q;
  assign reset_top         = idle_q;
  assign start             = start_q;

endmodule
